// File: rtl/data_memory_responder.sv
// data_memory_responder
// Word-addressed data memory on the target side of the load/store bus.
// It services one request at a time. Each request completes after a fixed,
// parameterised latency. Writes are applied per byte lane. Out-of-range and
// illegal requests are flagged on access_error.
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   address           word address, sampled in the request cycle
//   read_enable       one-cycle read request strobe
//   read_data         read word, valid with read_ack, held until the next read completes
//   read_ack          one-cycle read completion pulse
//   write_enable      one-cycle write request strobe
//   write_byte_enable byte-lane mask, bit i enables write_data[8i+7:8i]
//   write_data        lane-aligned store data, sampled in the request cycle
//   write_ack         one-cycle write completion pulse
//   busy              high while a request is outstanding (WAIT or ACK)
//   access_error      one-cycle pulse with the ack of an out-of-range/illegal request
module data_memory_responder #(
  parameter int DEPTH_WORDS   = 1024,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        read_ack,
  input  logic        write_enable,
  input  logic [3:0]  write_byte_enable,
  input  logic [31:0] write_data,
  output logic        write_ack,
  output logic        busy,
  output logic        access_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      state_r, state_next_s;
  logic [3:0]  cnt_r, cnt_next_s;
  logic [3:0]  lat_s;
  logic        capture_s, enter_ack_s;

  logic [31:0] req_addr_r;
  logic [3:0]  req_be_r;
  logic [31:0] req_data_r;
  logic        req_write_r;
  logic        req_illegal_r;

  // The request that is being completed. In IDLE it comes straight from the
  // bus, which covers latency 1. Otherwise it comes from the captured copy.
  logic [31:0] eff_addr_s;
  logic [3:0]  eff_be_s;
  logic [31:0] eff_data_s;
  logic        eff_write_s;
  logic        eff_illegal_s;
  logic        in_range_s;
  logic        mem_we_s;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_word_s;

  logic [31:0] read_data_next_s;
  logic        read_ack_next_s, write_ack_next_s, busy_next_s, access_error_next_s;

  // Select the live or captured request and derive range and commit controls.
  always_comb begin
    if (state_r == IDLE) begin
      eff_addr_s    = address;
      eff_be_s      = write_byte_enable;
      eff_data_s    = write_data;
      eff_write_s   = write_enable;
      eff_illegal_s = read_enable & write_enable;
    end else begin
      eff_addr_s    = req_addr_r;
      eff_be_s      = req_be_r;
      eff_data_s    = req_data_r;
      eff_write_s   = req_write_r;
      eff_illegal_s = req_illegal_r;
    end
    in_range_s = (eff_addr_s < 32'(DEPTH_WORDS));
    mem_word_s = mem[eff_addr_s[AW-1:0]];
    // A write whose completion edge coincides with a held reset is never committed.
    mem_we_s   = enter_ack_s & eff_write_s & in_range_s & ~rst;
    // A simultaneous read+write strobe is treated as a write.
    lat_s      = write_enable ? 4'(WRITE_LATENCY) : 4'(READ_LATENCY);
  end

  // Next-state logic. The WAIT counter holds the cycles remaining before ACK.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    capture_s    = 1'b0;
    enter_ack_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (read_enable | write_enable) begin
          capture_s = 1'b1;
          if (lat_s == 4'd1) begin
            state_next_s = ACK;
            enter_ack_s  = 1'b1;
          end else begin
            state_next_s = WAIT;
            cnt_next_s   = lat_s - 4'd1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd1) begin
          state_next_s = ACK;
          enter_ack_s  = 1'b1;
          cnt_next_s   = 4'd0;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      ACK:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Next values of the registered outputs. They are computed on the edge that enters ACK.
  always_comb begin
    read_data_next_s    = read_data;
    read_ack_next_s     = enter_ack_s & ~eff_write_s;
    write_ack_next_s    = enter_ack_s & eff_write_s;
    access_error_next_s = enter_ack_s & (eff_illegal_s | ~in_range_s);
    busy_next_s         = (state_next_s != IDLE);
    if (enter_ack_s & ~eff_write_s) begin
      read_data_next_s = in_range_s ? mem_word_s : 32'h0000_0000;
    end else begin
      read_data_next_s = read_data;
    end
  end

  // State, request capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      req_addr_r    <= 32'h0000_0000;
      req_be_r      <= 4'h0;
      req_data_r    <= 32'h0000_0000;
      req_write_r   <= 1'b0;
      req_illegal_r <= 1'b0;
      read_data     <= 32'h0000_0000;
      read_ack      <= 1'b0;
      write_ack     <= 1'b0;
      busy          <= 1'b0;
      access_error  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (capture_s) begin
        req_addr_r    <= address;
        req_be_r      <= write_byte_enable;
        req_data_r    <= write_data;
        req_write_r   <= write_enable;
        req_illegal_r <= read_enable & write_enable;
      end
      read_data    <= read_data_next_s;
      read_ack     <= read_ack_next_s;
      write_ack    <= write_ack_next_s;
      busy         <= busy_next_s;
      access_error <= access_error_next_s;
    end
  end

  // Storage array. It has no reset, and only the enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_be_s[i]) begin
          mem[eff_addr_s[AW-1:0]][8*i +: 8] <= eff_data_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Testbench for data_memory_responder. It uses three instances:
//   0: default latencies (1/1)
//   1: READ_LATENCY=3, WRITE_LATENCY=2
//   2: READ_LATENCY=1, WRITE_LATENCY=3 (reset mid-operation)
// Stimulus pushes expected acks into a scoreboard queue. A monitor per
// instance pops and compares whenever that instance acks.
module tb_data_memory_responder;

  localparam int DEPTH = 1024;

  typedef struct {
    int          dut;
    logic        is_write;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic [31:0] addr   [3];
  logic        re     [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata  [3];
  logic        rack   [3];
  logic        wack   [3];
  logic        busy   [3];
  logic        aerr   [3];

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1), .WRITE_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst[0]), .address(addr[0]), .read_enable(re[0]), .read_data(rdata[0]),
    .read_ack(rack[0]), .write_enable(we[0]), .write_byte_enable(be[0]), .write_data(wdata[0]),
    .write_ack(wack[0]), .busy(busy[0]), .access_error(aerr[0]));

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(3), .WRITE_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst[1]), .address(addr[1]), .read_enable(re[1]), .read_data(rdata[1]),
    .read_ack(rack[1]), .write_enable(we[1]), .write_byte_enable(be[1]), .write_data(wdata[1]),
    .write_ack(wack[1]), .busy(busy[1]), .access_error(aerr[1]));

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1), .WRITE_LATENCY(3)) dut_c (
    .clk(clk), .rst(rst[2]), .address(addr[2]), .read_enable(re[2]), .read_data(rdata[2]),
    .read_ack(rack[2]), .write_enable(we[2]), .write_byte_enable(be[2]), .write_data(wdata[2]),
    .write_ack(wack[2]), .busy(busy[2]), .access_error(aerr[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act === exp_v) begin
      passed++;
    end else begin
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Scoreboard monitors, one per instance.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    always @(negedge clk) begin
      if (rack[g] || wack[g]) begin
        if (sb.size() == 0 || sb[0].dut != g) begin
          chk($sformatf("unexpected_ack_dut%0d", g), {30'd0, rack[g], wack[g]}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("ack_kind_dut%0d", g), {30'd0, rack[g], wack[g]},
              e.is_write ? 32'd1 : 32'd2);
          if (!e.is_write) chk($sformatf("read_data_dut%0d", g), rdata[g], e.rdata);
          chk($sformatf("access_error_dut%0d", g), {31'd0, aerr[g]}, {31'd0, e.err});
          chk($sformatf("ack_cycle_dut%0d", g), 32'(cyc), 32'(e.cyc));
        end
      end else if (aerr[g]) begin
        chk($sformatf("stray_error_dut%0d", g), {31'd0, aerr[g]}, 32'd0);
      end
    end
  end

  // Drive one request in the current cycle and record its expected completion.
  task automatic start(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd, input logic ew,
                       input logic [31:0] erd, input logic eerr, input int lat);
    exp_t e;
    e.dut = d; e.is_write = ew; e.rdata = erd; e.err = eerr; e.cyc = cyc + lat;
    sb.push_back(e);
    re[d] = r; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    @(posedge clk); #1;
    re[d] = 1'b0; we[d] = 1'b0;
  endtask

  // Wait past the expected ack. The responder is back in IDLE afterwards.
  task automatic finish_wait(input int lat);
    repeat (lat) begin
      @(posedge clk); #1;
    end
    chk("ack_timeout_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic txn(input int d, input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] wd, input logic ew,
                     input logic [31:0] erd, input logic eerr, input int lat);
    start(d, r, w, a, b, wd, ew, erd, eerr, lat);
    finish_wait(lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; addr[i] = 32'd0; re[i] = 1'b0; we[i] = 1'b0;
      be[i] = 4'h0; wdata[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_read_data", rdata[i], 32'd0);
      chk("reset_read_ack", {31'd0, rack[i]}, 32'd0);
      chk("reset_write_ack", {31'd0, wack[i]}, 32'd0);
      chk("reset_busy", {31'd0, busy[i]}, 32'd0);
      chk("reset_access_error", {31'd0, aerr[i]}, 32'd0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(posedge clk); #1;

    // Default latencies: basic store and load.
    txn(0, 1'b0, 1'b1, 32'd5, 4'hF, 32'h1122_3344, 1'b1, 32'd0, 1'b0, 1);
    txn(0, 1'b1, 1'b0, 32'd5, 4'h0, 32'd0, 1'b0, 32'h1122_3344, 1'b0, 1);
    // Byte lanes.
    txn(0, 1'b0, 1'b1, 32'd5, 4'b0100, 32'h00AB_0000, 1'b1, 32'd0, 1'b0, 1);
    txn(0, 1'b1, 1'b0, 32'd5, 4'h0, 32'd0, 1'b0, 32'h11AB_3344, 1'b0, 1);
    txn(0, 1'b0, 1'b1, 32'd5, 4'b0011, 32'h0000_BEEF, 1'b1, 32'd0, 1'b0, 1);
    txn(0, 1'b1, 1'b0, 32'd5, 4'h0, 32'd0, 1'b0, 32'h11AB_BEEF, 1'b0, 1);
    // Empty byte mask: acked, no change.
    txn(0, 1'b0, 1'b1, 32'd5, 4'h0, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, 1);
    txn(0, 1'b1, 1'b0, 32'd5, 4'h0, 32'd0, 1'b0, 32'h11AB_BEEF, 1'b0, 1);
    // Out of range. Word 7 would be hit if the upper address bits were ignored.
    txn(0, 1'b0, 1'b1, 32'd7, 4'hF, 32'h7777_7777, 1'b1, 32'd0, 1'b0, 1);
    txn(0, 1'b1, 1'b0, 32'(DEPTH), 4'h0, 32'd0, 1'b0, 32'h0000_0000, 1'b1, 1);
    txn(0, 1'b0, 1'b1, 32'(DEPTH + 7), 4'hF, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1, 1);
    txn(0, 1'b1, 1'b0, 32'd7, 4'h0, 32'd0, 1'b0, 32'h7777_7777, 1'b0, 1);
    txn(0, 1'b1, 1'b0, 32'd5, 4'h0, 32'd0, 1'b0, 32'h11AB_BEEF, 1'b0, 1);
    // Simultaneous strobes: behaves as a flagged write.
    txn(0, 1'b1, 1'b1, 32'd9, 4'hF, 32'hCAFE_F00D, 1'b1, 32'd0, 1'b1, 1);
    txn(0, 1'b1, 1'b0, 32'd9, 4'h0, 32'd0, 1'b0, 32'hCAFE_F00D, 1'b0, 1);
    // read_data holds across a write.
    txn(0, 1'b0, 1'b1, 32'd10, 4'hF, 32'h1234_5678, 1'b1, 32'd0, 1'b0, 1);
    chk("read_data_hold", rdata[0], 32'hCAFE_F00D);

    // Longer latencies on instance 1.
    txn(1, 1'b0, 1'b1, 32'd3, 4'hF, 32'h0BAD_CAFE, 1'b1, 32'd0, 1'b0, 2);
    start(1, 1'b1, 1'b0, 32'd3, 4'h0, 32'd0, 1'b0, 32'h0BAD_CAFE, 1'b0, 3);
    // Strobes held through WAIT and ACK must be ignored.
    we[1] = 1'b1; addr[1] = 32'd3; be[1] = 4'hF; wdata[1] = 32'hDEAD_DEAD;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("busy_outstanding_k%0d", k), {31'd0, busy[1]}, 32'd1);
      @(posedge clk); #1;
    end
    we[1] = 1'b0;
    @(negedge clk);
    chk("busy_idle_after_ack", {31'd0, busy[1]}, 32'd0);
    chk("ack_timeout_queue_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    txn(1, 1'b1, 1'b0, 32'd3, 4'h0, 32'd0, 1'b0, 32'h0BAD_CAFE, 1'b0, 3);

    // Reset mid-operation on instance 2.
    txn(2, 1'b0, 1'b1, 32'd20, 4'hF, 32'h0000_0055, 1'b1, 32'd0, 1'b0, 3);
    txn(2, 1'b1, 1'b0, 32'd20, 4'h0, 32'd0, 1'b0, 32'h0000_0055, 1'b0, 1);
    we[2] = 1'b1; addr[2] = 32'd20; be[2] = 4'hF; wdata[2] = 32'h0000_00AA;
    @(posedge clk); #1;
    we[2] = 1'b0;
    @(negedge clk);
    chk("busy_before_reset", {31'd0, busy[2]}, 32'd1);
    #2 rst[2] = 1'b1;
    #1;
    chk("midreset_read_data", rdata[2], 32'd0);
    chk("midreset_read_ack", {31'd0, rack[2]}, 32'd0);
    chk("midreset_write_ack", {31'd0, wack[2]}, 32'd0);
    chk("midreset_busy", {31'd0, busy[2]}, 32'd0);
    chk("midreset_access_error", {31'd0, aerr[2]}, 32'd0);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    txn(2, 1'b1, 1'b0, 32'd20, 4'h0, 32'd0, 1'b0, 32'h0000_0055, 1'b0, 1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
